// File: rtl/counter_pkg.sv
// Shared types and defaults for the modulo-N counter family.
package counter_pkg;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } cnt_mode_e;

    localparam int CNT_WIDTH   = 4;
    localparam int CNT_MODULUS = 11;

    function automatic bit modulus_ok(int width, int modulus);
        return (width >= 1) && (modulus >= 2) &&
               (longint'(modulus) <= (longint'(1) << width));
    endfunction

endpackage

// File: rtl/modn_step.sv
// Next-count decode for one enabled step of a modulo-N counter.
module modn_step
    import counter_pkg::*;
#(
    parameter int WIDTH   = CNT_WIDTH,
    parameter int MODULUS = CNT_MODULUS
) (
    input  logic [WIDTH-1:0] count,
    input  logic             up_down,
    input  cnt_mode_e        mode,
    output logic [WIDTH-1:0] next_count,
    output logic             at_limit,
    output logic             wrap
);

    localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

    logic [WIDTH:0] count_ext;

    assign count_ext = {1'b0, count};

    // Away from the limit the step cannot overflow WIDTH bits.
    always_comb begin
        next_count = count;
        wrap       = 1'b0;
        at_limit   = up_down ? (count_ext == MAX_EXT) : (count_ext == '0);
        if (!at_limit) begin
            next_count = up_down ? count + WIDTH'(1) : count - WIDTH'(1);
        end else if (mode == MODE_WRAP) begin
            wrap       = 1'b1;
            next_count = up_down ? '0 : MAX_CNT;
        end
    end

endmodule

// File: rtl/modn_updown_counter.sv
// Loadable modulo-N up/down counter with wrap/saturate, tc and flags.
module modn_updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH   = CNT_WIDTH,
    parameter int MODULUS = CNT_MODULUS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic             up_down,
    input  cnt_mode_e        mode,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             rollover,
    output logic             load_err
);

    if (!modulus_ok(WIDTH, MODULUS)) begin : g_bad_param
        $fatal(1, "modn_updown_counter: need 2 <= MODULUS <= 2**WIDTH");
    end

    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             rollover_q, rollover_d;
    logic             load_err_q, load_err_d;
    logic [WIDTH-1:0] step_next;
    logic             step_limit;
    logic             step_wrap;
    logic             data_over;

    modn_step #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_step (
        .count      (count_q),
        .up_down    (up_down),
        .mode       (mode),
        .next_count (step_next),
        .at_limit   (step_limit),
        .wrap       (step_wrap)
    );

    // Compared one bit wider so MODULUS = 2**WIDTH is representable.
    assign data_over = ({1'b0, data} >= MOD_EXT);

    always_comb begin
        count_d    = count_q;
        rollover_d = 1'b0;
        load_err_d = 1'b0;
        if (load) begin
            if (data_over) begin
                count_d    = MAX_CNT;
                load_err_d = 1'b1;
            end else begin
                count_d = data;
            end
        end else if (en) begin
            count_d    = step_next;
            rollover_d = step_wrap;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            rollover_q <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            rollover_q <= rollover_d;
            load_err_q <= load_err_d;
        end
    end

    assign count    = count_q;
    assign tc       = step_limit;
    assign rollover = rollover_q;
    assign load_err = load_err_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert ({1'b0, count_q} < MOD_EXT)
            else $error("modn_updown_counter: count out of range");
        end
    end
`endif

endmodule

// File: tb/tb_modn_updown_counter.sv
// Randomised bench for modn_updown_counter with a behavioural model.
module tb_modn_updown_counter;
    import counter_pkg::*;

    localparam int N = 3;

    int mods [N] = '{11, 16, 5};
    int wids [N] = '{4, 4, 3};

    logic      clk = 1'b0;
    logic      rst;
    logic      en;
    logic      load;
    logic      up_down;
    cnt_mode_e mode;
    logic [3:0] data;

    logic [3:0] cnt0, cnt1;
    logic [2:0] cnt2;
    logic [N-1:0] tc_o, ro_o, le_o;

    int n_chk  = 0;
    int n_fail = 0;

    int m_cnt [N];
    int m_ro  [N];
    int m_le  [N];
    bit m_valid = 1'b0;

    always #5 clk = ~clk;

    modn_updown_counter #(.WIDTH(4), .MODULUS(11)) dut0 (
        .clk(clk), .rst(rst), .en(en), .load(load), .up_down(up_down),
        .mode(mode), .data(data), .count(cnt0), .tc(tc_o[0]),
        .rollover(ro_o[0]), .load_err(le_o[0])
    );

    modn_updown_counter #(.WIDTH(4), .MODULUS(16)) dut1 (
        .clk(clk), .rst(rst), .en(en), .load(load), .up_down(up_down),
        .mode(mode), .data(data), .count(cnt1), .tc(tc_o[1]),
        .rollover(ro_o[1]), .load_err(le_o[1])
    );

    modn_updown_counter #(.WIDTH(3), .MODULUS(5)) dut2 (
        .clk(clk), .rst(rst), .en(en), .load(load), .up_down(up_down),
        .mode(mode), .data(data[2:0]), .count(cnt2), .tc(tc_o[2]),
        .rollover(ro_o[2]), .load_err(le_o[2])
    );

    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int act_cnt(int k);
        case (k)
            0:       return int'(cnt0);
            1:       return int'(cnt1);
            default: return int'(cnt2);
        endcase
    endfunction

    // Reference: each edge is reset, load, step or hold on a plain integer.
    always @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            int m;
            int d;
            m = mods[k];
            d = int'(data) % (1 << wids[k]);
            if (rst) begin
                m_cnt[k] = 0; m_ro[k] = 0; m_le[k] = 0;
            end else if (load) begin
                m_ro[k] = 0;
                if (d >= m) begin
                    m_cnt[k] = m - 1; m_le[k] = 1;
                end else begin
                    m_cnt[k] = d; m_le[k] = 0;
                end
            end else begin
                m_ro[k] = 0; m_le[k] = 0;
                if (en && up_down) begin
                    if (m_cnt[k] < m - 1) m_cnt[k] = m_cnt[k] + 1;
                    else if (mode == MODE_WRAP) begin
                        m_cnt[k] = 0; m_ro[k] = 1;
                    end
                end else if (en) begin
                    if (m_cnt[k] > 0) m_cnt[k] = m_cnt[k] - 1;
                    else if (mode == MODE_WRAP) begin
                        m_cnt[k] = m - 1; m_ro[k] = 1;
                    end
                end
            end
        end
        if (rst) m_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            for (int k = 0; k < N; k++) begin
                int etc;
                etc = up_down ? int'(m_cnt[k] == mods[k] - 1) : int'(m_cnt[k] == 0);
                chk($sformatf("count[M=%0d]", mods[k]), act_cnt(k), m_cnt[k]);
                chk($sformatf("tc[M=%0d]", mods[k]), int'(tc_o[k]), etc);
                chk($sformatf("rollover[M=%0d]", mods[k]), int'(ro_o[k]), m_ro[k]);
                chk($sformatf("load_err[M=%0d]", mods[k]), int'(le_o[k]), m_le[k]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int exp_w [4];
        int exp_s [4];
        exp_w = '{1, 0, 10, 9};
        exp_s = '{1, 0, 0, 0};
        rst = 1'b1; en = 1'b0; load = 1'b0; up_down = 1'b1;
        mode = MODE_WRAP; data = 4'd0;
        tick(); tick();
        chk("reset_count", int'(cnt0), 0);
        chk("reset_rollover", int'(ro_o[0]), 0);
        chk("reset_load_err", int'(le_o[0]), 0);

        rst = 1'b0; en = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk("up_count", int'(cnt0), i % 11);
            chk("up_rollover", int'(ro_o[0]), int'(i == 11));
            chk("up_tc", int'(tc_o[0]), int'(i % 11 == 10));
        end
        chk("up_count_m16", int'(cnt1), 12);
        chk("up_count_m5", int'(cnt2), 2);

        load = 1'b1; data = 4'd2; up_down = 1'b0;
        tick();
        load = 1'b0;
        chk("load2", int'(cnt0), 2);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("down_wrap_count", int'(cnt0), exp_w[i]);
            chk("down_wrap_rollover", int'(ro_o[0]), int'(i == 2));
        end
        load = 1'b1; mode = MODE_SAT;
        tick();
        load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("down_sat_count", int'(cnt0), exp_s[i]);
            chk("down_sat_rollover", int'(ro_o[0]), 0);
        end

        load = 1'b1; data = 4'd13; mode = MODE_WRAP;
        tick();
        chk("clamp_count", int'(cnt0), 10);
        chk("clamp_err", int'(le_o[0]), 1);
        data = 4'd5;
        tick();
        chk("reload_count", int'(cnt0), 5);
        chk("reload_err", int'(le_o[0]), 0);

        rst = 1'b1; data = 4'd7; up_down = 1'b1;
        tick();
        chk("prio_rst", int'(cnt0), 0);
        rst = 1'b0;
        tick();
        chk("prio_load", int'(cnt0), 7);

        load = 1'b0; en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_count", int'(cnt0), 7);
        end
        load = 1'b1; data = 4'd10;
        tick();
        chk("pre_rst_count", int'(cnt0), 10);
        load = 1'b0; en = 1'b1; rst = 1'b1;
        tick();
        chk("mid_rst_count", int'(cnt0), 0);
        chk("mid_rst_rollover", int'(ro_o[0]), 0);
        rst = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom_range(0, 31) == 0);
            load    = ($urandom_range(0, 7) == 0);
            en      = ($urandom_range(0, 3) != 0);
            up_down = $urandom_range(0, 1) != 0;
            mode    = ($urandom_range(0, 1) != 0) ? MODE_SAT : MODE_WRAP;
            data    = 4'($urandom_range(0, 15));
            tick();
        end

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
